// File: rtl/i2c_xfer_sched_pkg.sv
// Shared types for the I2C transaction scheduler: FSM states, latched request
// payload and one format-FIFO entry.
package i2c_xfer_sched_pkg;

    localparam int unsigned AddrW = 7;
    localparam int unsigned DataW = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_W,
        REG,
        DATA,
        ADDR_R,
        READ,
        WAIT_RX,
        DONE
    } state_e;

    typedef struct packed {
        logic [AddrW-1:0] addr;
        logic [DataW-1:0] reg_idx;
        logic             we;
        logic [DataW-1:0] wdata;
    } xfer_req_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic             start;
        logic             stop;
        logic             read;
    } fmt_entry_t;

    // Build one format-FIFO entry.
    function automatic fmt_entry_t mk_fmt(logic [DataW-1:0] data, logic start,
                                          logic stop, logic read);
        fmt_entry_t e;
        e.data  = data;
        e.start = start;
        e.stop  = stop;
        e.read  = read;
        return e;
    endfunction

endpackage

// File: rtl/i2c_rr_arb.sv
// Combinational round-robin arbiter.
//   valid_i : request vector
//   ptr_i   : index of the last granted requester (search starts at ptr_i+1)
//   en_i    : arbitration enable; no grant when low
//   gnt_o   : one-hot grant
//   idx_o   : index of the granted requester
//   any_o   : a grant is being issued
module i2c_rr_arb #(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   ptr_i,
    input  logic              en_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    // Scan ptr+1 .. ptr+NumReq (mod NumReq); first valid candidate wins.
    always_comb begin
        int unsigned cand;
        cand  = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned i = 1; i <= NumReq; i++) begin
            cand = (32'(ptr_i) + i) % NumReq;
            if (en_i && !any_o && valid_i[IdxW'(cand)]) begin
                any_o              = 1'b1;
                idx_o              = IdxW'(cand);
                gnt_o[IdxW'(cand)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_xfer_sched.sv
// Arbitrates single-byte register transactions from NumReq requesters and
// expands each into I2C host format-FIFO entries; collects the RX byte of
// reads and returns a one-cycle response to the granted requester.
//   req_*       : per-requester request (flattened vectors), one-hot accept
//   rsp_*       : one-hot completion pulse with read data / error
//   fmt_*       : format-FIFO entry stream toward i2c_core
//   rx_*        : RX FIFO pop interface
//   host_nak_i  : target NAK pulse from the host
//   busy_o      : a transaction is in progress
module i2c_xfer_sched
    import i2c_xfer_sched_pkg::*;
#(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumReq-1:0]     req_valid_i,
    output logic [NumReq-1:0]     req_ready_o,
    input  logic [NumReq*7-1:0]   req_addr_i,
    input  logic [NumReq*8-1:0]   req_reg_i,
    input  logic [NumReq-1:0]     req_we_i,
    input  logic [NumReq*8-1:0]   req_wdata_i,
    output logic [NumReq-1:0]     rsp_valid_o,
    output logic [7:0]            rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  fmt_valid_o,
    input  logic                  fmt_ready_i,
    output logic [7:0]            fmt_byte_o,
    output logic                  fmt_start_o,
    output logic                  fmt_stop_o,
    output logic                  fmt_read_o,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  rx_ready_o,
    input  logic                  host_nak_i,
    output logic                  busy_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    state_e          state_q, state_d;
    xfer_req_t       req_q, req_d;
    logic [IdxW-1:0] gidx_q, gidx_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            err_q, err_d;

    xfer_req_t       reqs [NumReq];
    fmt_entry_t      fmt_c;
    logic            arb_en;
    logic [NumReq-1:0] arb_gnt;
    logic [IdxW-1:0] arb_idx;
    logic            arb_any;

    // Unpack the flattened request ports into per-requester payloads.
    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            reqs[i].addr    = req_addr_i[i*AddrW +: AddrW];
            reqs[i].reg_idx = req_reg_i[i*DataW +: DataW];
            reqs[i].we      = req_we_i[i];
            reqs[i].wdata   = req_wdata_i[i*DataW +: DataW];
        end
    end

    // Grants only happen in IDLE and never while reset is held.
    assign arb_en = (state_q == IDLE) && !rst_i;

    i2c_rr_arb #(
        .NumReq (NumReq)
    ) u_arb (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .en_i    (arb_en),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign req_ready_o = arb_gnt;
    assign fmt_byte_o  = fmt_c.data;
    assign fmt_start_o = fmt_c.start;
    assign fmt_stop_o  = fmt_c.stop;
    assign fmt_read_o  = fmt_c.read;

    // State register and datapath flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= IdxW'(NumReq - 1);
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output decode; outputs forced to 0 while reset is held.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        fmt_c       = '0;
        fmt_valid_o = 1'b0;
        rx_ready_o  = 1'b0;
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        rsp_err_o   = 1'b0;
        busy_o      = 1'b0;

        if (!rst_i) begin
            busy_o = (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        req_d   = reqs[arb_idx];
                        gidx_d  = arb_idx;
                        ptr_d   = arb_idx;
                        rdata_d = '0;
                        err_d   = 1'b0;
                        state_d = ADDR_W;
                    end
                end
                ADDR_W: begin
                    fmt_valid_o = 1'b1;
                    fmt_c       = mk_fmt({req_q.addr, 1'b0}, 1'b1, 1'b0, 1'b0);
                    if (fmt_ready_i) state_d = REG;
                end
                REG: begin
                    fmt_valid_o = 1'b1;
                    fmt_c       = mk_fmt(req_q.reg_idx, 1'b0, 1'b0, 1'b0);
                    if (fmt_ready_i) state_d = req_q.we ? DATA : ADDR_R;
                end
                DATA: begin
                    fmt_valid_o = 1'b1;
                    fmt_c       = mk_fmt(req_q.wdata, 1'b0, 1'b1, 1'b0);
                    if (fmt_ready_i) state_d = DONE;
                end
                ADDR_R: begin
                    fmt_valid_o = 1'b1;
                    fmt_c       = mk_fmt({req_q.addr, 1'b1}, 1'b1, 1'b0, 1'b0);
                    if (fmt_ready_i) state_d = READ;
                end
                READ: begin
                    fmt_valid_o = 1'b1;
                    fmt_c       = mk_fmt(8'd1, 1'b0, 1'b1, 1'b1);
                    if (fmt_ready_i) begin
                        cnt_d   = '0;
                        state_d = WAIT_RX;
                    end
                end
                WAIT_RX: begin
                    rx_ready_o = 1'b1;
                    // Data arriving on the last allowed cycle still wins.
                    if (rx_valid_i) begin
                        rdata_d = rx_data_i;
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else if (cnt_q == CntLast) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    rsp_valid_o[gidx_q] = 1'b1;
                    rsp_rdata_o         = rdata_q;
                    rsp_err_o           = err_q;
                    state_d             = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // NAK aborts any active phase and overrides handshakes/RX data.
            if (host_nak_i && (state_q != IDLE) && (state_q != DONE)) begin
                rdata_d = '0;
                err_d   = 1'b1;
                state_d = DONE;
            end
        end
    end

endmodule

// File: tb/tb_i2c_xfer_sched.sv
// Bench for i2c_xfer_sched: directed and randomized transactions checked
// against a transaction-level model of the expected format stream, arbitration
// order and responses.
module tb_i2c_xfer_sched;

    localparam int NR = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [NR-1:0]   req_valid_i;
    logic [NR-1:0]   req_ready_o;
    logic [NR*7-1:0] req_addr_i;
    logic [NR*8-1:0] req_reg_i;
    logic [NR-1:0]   req_we_i;
    logic [NR*8-1:0] req_wdata_i;
    logic [NR-1:0]   rsp_valid_o;
    logic [7:0]      rsp_rdata_o;
    logic            rsp_err_o;
    logic            fmt_valid_o;
    logic            fmt_ready_i;
    logic [7:0]      fmt_byte_o;
    logic            fmt_start_o;
    logic            fmt_stop_o;
    logic            fmt_read_o;
    logic            rx_valid_i;
    logic [7:0]      rx_data_i;
    logic            rx_ready_o;
    logic            host_nak_i;
    logic            busy_o;

    always #5 clk = ~clk;

    i2c_xfer_sched #(
        .NumReq        (NR),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_reg_i   (req_reg_i),
        .req_we_i    (req_we_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .fmt_valid_o (fmt_valid_o),
        .fmt_ready_i (fmt_ready_i),
        .fmt_byte_o  (fmt_byte_o),
        .fmt_start_o (fmt_start_o),
        .fmt_stop_o  (fmt_stop_o),
        .fmt_read_o  (fmt_read_o),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_ready_o  (rx_ready_o),
        .host_nak_i  (host_nak_i),
        .busy_o      (busy_o)
    );

    int n_vec = 0;
    int n_bad = 0;
    int last_g;
    logic [10:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'(1 << i);
    endfunction

    function automatic logic [31:0] all_out();
        return 32'({req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, fmt_valid_o,
                    fmt_byte_o, fmt_start_o, fmt_stop_o, fmt_read_o, rx_ready_o, busy_o});
    endfunction

    function automatic logic [31:0] fmt_obs();
        return 32'({fmt_start_o, fmt_stop_o, fmt_read_o, fmt_byte_o});
    endfunction

    // Expected I2C format stream for one register transaction: {start,stop,read,byte}.
    task automatic model_fmt(input bit we, input logic [6:0] a, input logic [7:0] rg,
                             input logic [7:0] wd);
        exp_q.delete();
        exp_q.push_back({1'b1, 1'b0, 1'b0, a, 1'b0});
        exp_q.push_back({1'b0, 1'b0, 1'b0, rg});
        if (we) begin
            exp_q.push_back({1'b0, 1'b1, 1'b0, wd});
        end else begin
            exp_q.push_back({1'b1, 1'b0, 1'b0, a, 1'b1});
            exp_q.push_back({1'b0, 1'b1, 1'b1, 8'd1});
        end
    endtask

    // Present a single request, check the grant, then drop it.
    task automatic issue(input int r, input bit we, input logic [6:0] a, input logic [7:0] rg,
                         input logic [7:0] wd);
        req_addr_i[r*7 +: 7]  = a;
        req_reg_i[r*8 +: 8]   = rg;
        req_we_i[r]           = we;
        req_wdata_i[r*8 +: 8] = wd;
        req_valid_i           = oh(r);
        settle();
        chk("grant", 32'(req_ready_o), 32'(oh(r)));
        last_g = r;
        cyc();
        req_valid_i = '0;
        model_fmt(we, a, rg, wd);
    endtask

    // Consume the expected format stream, optionally with random backpressure.
    task automatic drain(input bit rnd, output int n);
        int guard;
        guard = 0;
        n     = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            fmt_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            settle();
            chk("fmt_valid", 32'(fmt_valid_o), 32'd1);
            chk("fmt_entry", fmt_obs(), 32'(exp_q[0]));
            if (fmt_ready_i) void'(exp_q.pop_front());
            cyc();
            n++;
            guard++;
        end
        fmt_ready_i = 1'b0;
        chk("fmt_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Full transaction; rx_at / nak_at are WAIT_RX cycle indices (-1 = never).
    task automatic xfer(input int r, input bit we, input logic [6:0] a, input logic [7:0] rg,
                        input logic [7:0] wd, input int rx_at, input logic [7:0] rxd,
                        input int nak_at, input bit rnd);
        int n;
        int last_k;
        logic [7:0] erd;
        logic eerr;
        issue(r, we, a, rg, wd);
        drain(rnd, n);
        if (!rnd && we) chk("wr_latency", 32'(n + 1), 32'd4);
        erd  = '0;
        eerr = 1'b0;
        if (!we) begin
            last_k = (rx_at >= 0 && rx_at < TO) ? rx_at : TO - 1;
            if (nak_at >= 0 && nak_at <= last_k) begin
                last_k = nak_at;
                eerr   = 1'b1;
            end else if (rx_at >= 0 && rx_at < TO) begin
                erd = rxd;
            end else begin
                eerr = 1'b1;
            end
            for (int k = 0; k <= last_k; k++) begin
                rx_valid_i = (k == rx_at);
                rx_data_i  = rxd;
                host_nak_i = (k == nak_at);
                settle();
                chk("rx_ready", 32'(rx_ready_o), 32'd1);
                chk("rsp_early", 32'(rsp_valid_o), 32'd0);
                cyc();
            end
            rx_valid_i = 1'b0;
            host_nak_i = 1'b0;
        end
        settle();
        chk("rsp_valid", 32'(rsp_valid_o), 32'(oh(r)));
        chk("rsp_rdata", 32'(rsp_rdata_o), 32'(erd));
        chk("rsp_err", 32'(rsp_err_o), 32'(eerr));
        cyc();
        chk("idle_after", 32'({busy_o, rsp_valid_o, fmt_valid_o}), 32'd0);
    endtask

    initial begin
        int n;
        int g;
        int c;
        logic [3:0] pend;
        logic [3:0] newp;
        logic [6:0] ea;

        rst_i       = 1'b1;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_reg_i   = '0;
        req_we_i    = '0;
        req_wdata_i = '0;
        fmt_ready_i = 1'b0;
        rx_valid_i  = 1'b0;
        rx_data_i   = '0;
        host_nak_i  = 1'b0;
        last_g      = NR - 1;
        settle();
        chk("rst_during", all_out(), 32'd0);
        cyc();
        cyc();
        chk("rst_held", all_out(), 32'd0);
        rst_i = 1'b0;
        settle();
        chk("post_rst", all_out(), 32'd0);

        // Directed write and read.
        xfer(0, 1'b1, 7'h50, 8'h10, 8'hA5, -1, 8'h00, -1, 1'b0);
        xfer(2, 1'b0, 7'h3C, 8'h07, 8'h00, 10, 8'h5A, -1, 1'b0);

        // Timeout boundaries: no data, data on the last cycle, data too late.
        xfer(1, 1'b0, 7'h11, 8'h22, 8'h00, -1, 8'hEE, -1, 1'b0);
        xfer(3, 1'b0, 7'h12, 8'h23, 8'h00, TO - 1, 8'hC3, -1, 1'b0);
        xfer(0, 1'b0, 7'h13, 8'h24, 8'h00, TO, 8'h3C, -1, 1'b0);

        // NAK coinciding with RX data in WAIT_RX.
        xfer(1, 1'b0, 7'h33, 8'h44, 8'h00, 5, 8'h99, 5, 1'b0);

        // NAK while idle is ignored.
        host_nak_i = 1'b1;
        settle();
        cyc();
        host_nak_i = 1'b0;
        settle();
        chk("nak_idle", all_out(), 32'd0);

        // NAK while stalled in REG.
        issue(0, 1'b1, 7'h22, 8'h33, 8'h44);
        fmt_ready_i = 1'b1;
        settle();
        chk("nak_addr_w", fmt_obs(), 32'(exp_q[0]));
        cyc();
        fmt_ready_i = 1'b0;
        host_nak_i  = 1'b1;
        settle();
        chk("nak_reg_valid", 32'(fmt_valid_o), 32'd1);
        chk("nak_reg_entry", fmt_obs(), 32'(exp_q[1]));
        cyc();
        host_nak_i  = 1'b0;
        fmt_ready_i = 1'b1;
        settle();
        chk("nak_rsp", 32'({rsp_valid_o, rsp_err_o, rsp_rdata_o, fmt_valid_o}),
            32'({oh(0), 1'b1, 8'h00, 1'b0}));
        cyc();
        chk("nak_after", all_out(), 32'd0);
        fmt_ready_i = 1'b0;

        // Randomized transactions with backpressure, late data and NAKs.
        for (int it = 0; it < 10; it++) begin
            xfer(int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)), 7'($urandom),
                 8'($urandom), 8'($urandom), int'($urandom_range(0, 20)), 8'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1, 1'b1);
        end

        // Round-robin arbitration with all requesters contending from reset.
        rst_i = 1'b1;
        cyc();
        rst_i  = 1'b0;
        last_g = NR - 1;
        for (int j = 0; j < NR; j++) req_addr_i[j*7 +: 7] = 7'($urandom);
        req_we_i    = '1;
        pend        = 4'hF;
        fmt_ready_i = 1'b1;
        for (int it = 0; it < 12; it++) begin
            if (pend == 4'h0) pend = oh(int'($urandom_range(0, NR - 1)));
            req_valid_i = pend;
            settle();
            g = -1;
            for (int i = 1; i <= NR; i++) begin
                c = (last_g + i) % NR;
                if (g < 0 && pend[c]) g = c;
            end
            chk("arb_grant", 32'(req_ready_o), 32'(oh(g)));
            ea      = req_addr_i[g*7 +: 7];
            last_g  = g;
            pend[g] = 1'b0;
            cyc();
            req_valid_i = pend;
            settle();
            chk("arb_addr", 32'(fmt_byte_o), 32'({ea, 1'b0}));
            chk("arb_hold", 32'(req_ready_o), 32'd0);
            cyc();
            cyc();
            cyc();
            chk("arb_rsp", 32'(rsp_valid_o), 32'(oh(g)));
            chk("arb_done_nogrant", 32'(req_ready_o), 32'd0);
            newp = 4'($urandom_range(0, 15));
            for (int j = 0; j < NR; j++)
                if (newp[j] && !pend[j]) req_addr_i[j*7 +: 7] = 7'($urandom);
            pend = pend | newp;
            cyc();
        end
        req_valid_i = '0;
        fmt_ready_i = 1'b0;
        settle();
        cyc();

        // Reset in WAIT_RX abandons the read; requester 0 wins afterwards.
        issue(1, 1'b0, 7'h45, 8'h67, 8'h00);
        drain(1'b1, n);
        cyc();
        cyc();
        cyc();
        rst_i                = 1'b1;
        rx_valid_i           = 1'b1;
        rx_data_i            = 8'h77;
        req_addr_i[0 +: 7]   = 7'h0F;
        req_reg_i[0 +: 8]    = 8'h01;
        req_we_i[0]          = 1'b1;
        req_wdata_i[0 +: 8]  = 8'h02;
        req_valid_i          = 4'b0011;
        settle();
        chk("rst_mid", all_out(), 32'd0);
        cyc();
        chk("rst_mid_held", all_out(), 32'd0);
        rst_i      = 1'b0;
        rx_valid_i = 1'b0;
        settle();
        chk("rst_prio", 32'(req_ready_o), 32'(oh(0)));
        chk("rst_no_rsp", 32'(rsp_valid_o), 32'd0);
        cyc();
        req_valid_i = '0;
        model_fmt(1'b1, 7'h0F, 8'h01, 8'h02);
        drain(1'b0, n);
        settle();
        chk("rst_wr_rsp", 32'({rsp_valid_o, rsp_err_o, rsp_rdata_o}), 32'({oh(0), 1'b0, 8'h00}));
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
